// File: rtl/branch_resolve_pkg.sv
// Shared levels, widths and opcode constants for the branch-resolution slice.
package branch_resolve_pkg;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  localparam int InstAddrBus = 32;
  localparam int HistWDef    = 10;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  function automatic logic is_branch_op(input logic [6:0] opcode);
    return opcode == OPCODE_BRANCH;
  endfunction

endpackage

// File: rtl/branch_resolve_bp_meta_fifo.sv
// Circular FIFO of prediction metadata; clear drops everything behind the entry being popped.
import branch_resolve_pkg::*;

module bp_meta_fifo #(
  parameter int W     = 76,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    rd_d  = rd_q + PW'(pop_i);
    wr_d  = wr_q + PW'(push_i);
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    if (clear_i) begin
      wr_d  = rd_d;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst != RstDisable) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/branch_resolve.sv
// Matches ID branch outcomes against queued IF predictions; drives predictor update and flush.
import branch_resolve_pkg::*;

module branch_resolve #(
  parameter int DEPTH  = 4,
  parameter int HIST_W = HistWDef,
  parameter int ADDR_W = InstAddrBus,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_push,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_pdt_res,
  input  logic              if_which_pdt,
  input  logic [HIST_W-1:0] if_history,
  input  logic [ADDR_W-1:0] if_pdt_pc,
  input  logic              id_resolve,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              id_taken,
  input  logic [ADDR_W-1:0] id_target,
  output logic              if_stall,
  output logic              upd_valid,
  output logic              upd_branch_res,
  output logic              upd_pdt_true,
  output logic              upd_which_pdt,
  output logic [ADDR_W-1:0] upd_pc,
  output logic [HIST_W-1:0] upd_history,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              spurious,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispred
);

  localparam int EW = 2 * ADDR_W + HIST_W + 2;

  // Handshake: a prediction is accepted on any edge where if_push=1 and if_stall=0,
  // unless the same edge flushes (wrong-path push); ID resolves are never back-pressured.
  logic [EW-1:0]     head;
  logic              fifo_full, fifo_empty;
  logic              pop, push, pc_mismatch, mispredict, flush_now, spurious_now;
  logic [ADDR_W-1:0] head_pc, head_pdt_pc;
  logic              head_pdt_res, head_which;
  logic [HIST_W-1:0] head_hist;

  logic              upd_valid_q, upd_branch_res_q, upd_pdt_true_q, upd_which_q;
  logic [ADDR_W-1:0] upd_pc_q, redirect_q;
  logic [HIST_W-1:0] upd_hist_q;
  logic              flush_q, spurious_q;
  logic [CNT_W-1:0]  stat_br_q, stat_mis_q;

  assign head_pc      = head[EW-1 -: ADDR_W];
  assign head_pdt_res = head[ADDR_W + HIST_W + 1];
  assign head_which   = head[ADDR_W + HIST_W];
  assign head_hist    = head[ADDR_W +: HIST_W];
  assign head_pdt_pc  = head[ADDR_W-1:0];

  assign pop          = id_resolve && !fifo_empty;
  assign if_stall     = fifo_full && !pop;
  assign pc_mismatch  = (head_pc != id_pc);
  assign mispredict   = pc_mismatch || (head_pdt_res != id_taken) ||
                        (id_taken && (head_pdt_pc != id_target));
  assign flush_now    = pop && mispredict;
  assign spurious_now = id_resolve && (fifo_empty || pc_mismatch);
  assign push         = if_push && !if_stall && !flush_now;

  bp_meta_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (flush_now),
    .wdata_i ({if_pc, if_pdt_res, if_which_pdt, if_history, if_pdt_pc}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      upd_valid_q      <= 1'b0;
      upd_branch_res_q <= 1'b0;
      upd_pdt_true_q   <= 1'b0;
      upd_which_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_hist_q       <= '0;
      flush_q          <= 1'b0;
      redirect_q       <= '0;
      spurious_q       <= 1'b0;
      stat_br_q        <= '0;
      stat_mis_q       <= '0;
    end else begin
      upd_valid_q <= pop;
      flush_q     <= flush_now;
      spurious_q  <= spurious_now;
      // Data fields only move with their pulse so the predictor can sample late.
      if (pop) begin
        upd_branch_res_q <= id_taken;
        upd_pdt_true_q   <= !mispredict;
        upd_which_q      <= head_which;
        upd_pc_q         <= head_pc;
        upd_hist_q       <= head_hist;
        if (stat_br_q != '1) stat_br_q <= stat_br_q + CNT_W'(1);
        if (mispredict && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + CNT_W'(1);
      end
      if (flush_now) redirect_q <= id_target;
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_branch_res = upd_branch_res_q;
  assign upd_pdt_true   = upd_pdt_true_q;
  assign upd_which_pdt  = upd_which_q;
  assign upd_pc         = upd_pc_q;
  assign upd_history    = upd_hist_q;
  assign flush          = flush_q;
  assign redirect_pc    = redirect_q;
  assign spurious       = spurious_q;
  assign stat_branches  = stat_br_q;
  assign stat_mispred   = stat_mis_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus a randomized run against a queue model.
module tb_branch_resolve;

  localparam int DEPTH  = 4;
  localparam int HIST_W = 10;
  localparam int ADDR_W = 32;
  localparam int ENT_W  = 2 * ADDR_W + HIST_W + 2;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              if_push, if_pdt_res, if_which_pdt;
  logic [ADDR_W-1:0] if_pc, if_pdt_pc;
  logic [HIST_W-1:0] if_history;
  logic              id_resolve, id_taken;
  logic [ADDR_W-1:0] id_pc, id_target;

  logic              if_stall, upd_valid, upd_branch_res, upd_pdt_true, upd_which_pdt;
  logic [ADDR_W-1:0] upd_pc, redirect_pc;
  logic [HIST_W-1:0] upd_history;
  logic              flush, spurious;
  logic [31:0]       stat_branches, stat_mispred;

  logic              s_if_stall, s_upd_valid, s_upd_branch_res, s_upd_pdt_true, s_upd_which_pdt;
  logic [ADDR_W-1:0] s_upd_pc, s_redirect_pc;
  logic [HIST_W-1:0] s_upd_history;
  logic              s_flush, s_spurious;
  logic [2:0]        s_stat_branches, s_stat_mispred;

  branch_resolve #(.DEPTH(DEPTH), .HIST_W(HIST_W), .ADDR_W(ADDR_W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_push(if_push), .if_pc(if_pc), .if_pdt_res(if_pdt_res),
    .if_which_pdt(if_which_pdt), .if_history(if_history), .if_pdt_pc(if_pdt_pc),
    .id_resolve(id_resolve), .id_pc(id_pc), .id_taken(id_taken), .id_target(id_target),
    .if_stall(if_stall), .upd_valid(upd_valid), .upd_branch_res(upd_branch_res),
    .upd_pdt_true(upd_pdt_true), .upd_which_pdt(upd_which_pdt), .upd_pc(upd_pc),
    .upd_history(upd_history), .flush(flush), .redirect_pc(redirect_pc),
    .spurious(spurious), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  // Narrow-counter copy on the same inputs: reaches saturation within a short run.
  branch_resolve #(.DEPTH(DEPTH), .HIST_W(HIST_W), .ADDR_W(ADDR_W), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .if_push(if_push), .if_pc(if_pc), .if_pdt_res(if_pdt_res),
    .if_which_pdt(if_which_pdt), .if_history(if_history), .if_pdt_pc(if_pdt_pc),
    .id_resolve(id_resolve), .id_pc(id_pc), .id_taken(id_taken), .id_target(id_target),
    .if_stall(s_if_stall), .upd_valid(s_upd_valid), .upd_branch_res(s_upd_branch_res),
    .upd_pdt_true(s_upd_pdt_true), .upd_which_pdt(s_upd_which_pdt), .upd_pc(s_upd_pc),
    .upd_history(s_upd_history), .flush(s_flush), .redirect_pc(s_redirect_pc),
    .spurious(s_spurious), .stat_branches(s_stat_branches), .stat_mispred(s_stat_mispred)
  );

  // ---------------- reference model ----------------
  logic [ENT_W-1:0] exp_q[$];
  logic        m_stall, m_upd_valid, m_br_res, m_pdt_true, m_which, m_flush, m_spur;
  logic [31:0] m_upd_pc, m_redirect, m_sb, m_sm;
  logic [9:0]  m_hist;
  logic [2:0]  m_ssb, m_ssm;
  logic        obs_stall;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [ENT_W-1:0] pack(input logic [31:0] pc, input logic pdt,
                                           input logic wh, input logic [9:0] hs,
                                           input logic [31:0] ptgt);
    return {pc, pdt, wh, hs, ptgt};
  endfunction

  function automatic logic [31:0] head_pc_of(input logic [ENT_W-1:0] e);
    return e[ENT_W-1 -: 32];
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic p, input logic [31:0] ppc, input logic pdt,
                       input logic wh, input logic [9:0] hs, input logic [31:0] ptgt,
                       input logic rs, input logic [31:0] ipc, input logic tk,
                       input logic [31:0] tgt);
    logic [ENT_W-1:0] h;
    logic [31:0] h_pc, h_ptgt;
    logic h_pdt, mis;
    @(negedge clk);
    rst = r; if_push = p; if_pc = ppc; if_pdt_res = pdt; if_which_pdt = wh;
    if_history = hs; if_pdt_pc = ptgt; id_resolve = rs; id_pc = ipc; id_taken = tk;
    id_target = tgt;
    #1 obs_stall = if_stall;
    mis = 1'b0;
    m_stall = (exp_q.size() == DEPTH) && !(rs && exp_q.size() > 0);
    if (!r) begin
      exp_q.delete();
      {m_upd_valid, m_br_res, m_pdt_true, m_which, m_flush, m_spur} = '0;
      m_upd_pc = '0; m_redirect = '0; m_hist = '0; m_sb = '0; m_sm = '0;
      m_ssb = '0; m_ssm = '0;
    end else begin
      m_upd_valid = 1'b0; m_flush = 1'b0; m_spur = 1'b0;
      if (rs) begin
        if (exp_q.size() == 0) begin
          m_spur = 1'b1;
        end else begin
          h = exp_q.pop_front();
          h_pc = h[ENT_W-1 -: 32]; h_pdt = h[ENT_W-33]; h_ptgt = h[31:0];
          mis = (h_pc != ipc) || (h_pdt != tk) || (tk && h_ptgt != tgt);
          m_upd_valid = 1'b1; m_br_res = tk; m_pdt_true = !mis;
          m_which = h[ENT_W-34]; m_hist = h[41:32]; m_upd_pc = h_pc;
          m_sb  = (m_sb  == ALL1) ? m_sb  : m_sb + 1;
          m_ssb = (m_ssb == 3'd7) ? m_ssb : m_ssb + 3'd1;
          if (mis) begin
            m_sm  = (m_sm  == ALL1) ? m_sm  : m_sm + 1;
            m_ssm = (m_ssm == 3'd7) ? m_ssm : m_ssm + 3'd1;
            m_flush = 1'b1; m_redirect = tgt;
            exp_q.delete();
          end
          if (h_pc != ipc) m_spur = 1'b1;
        end
      end
      if (p && !m_stall && !mis) exp_q.push_back(pack(ppc, pdt, wh, hs, ptgt));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_e(input logic [31:0] pc, input logic pdt, input logic wh,
                        input logic [9:0] hs, input logic [31:0] ptgt);
    cycle(1, 1, pc, pdt, wh, hs, ptgt, 0, 0, 0, 0);
  endtask

  task automatic resolve_e(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, pc, tk, tgt);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid got %0b want 0", upd_valid); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL reset_flush got %0b want 0", flush); else n_pass++;
    n_checks++; if (spurious !== 1'b0) $display("FAIL reset_spurious got %0b want 0", spurious); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h0) $display("FAIL reset_redirect got %h want 0", redirect_pc); else n_pass++;
    n_checks++; if ({stat_branches, stat_mispred} !== 64'h0) $display("FAIL reset_stats got %h/%h want 0/0", stat_branches, stat_mispred); else n_pass++;
    n_checks++; if ({upd_pc, upd_history, upd_pdt_true} !== '0) $display("FAIL reset_upd_fields got %h/%h/%0b want 0", upd_pc, upd_history, upd_pdt_true); else n_pass++;
    n_checks++; if (if_stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", if_stall); else n_pass++;
  endtask

  task automatic test_correct();
    push_e(32'h100, 1, 0, 10'h2A5, 32'h140);
    resolve_e(32'h100, 1, 32'h140);
    n_checks++; if (upd_valid !== 1'b1) $display("FAIL correct_upd_valid got %0b want 1", upd_valid); else n_pass++;
    n_checks++; if (upd_pdt_true !== 1'b1) $display("FAIL correct_pdt_true got %0b want 1", upd_pdt_true); else n_pass++;
    n_checks++; if (upd_which_pdt !== 1'b0 || upd_branch_res !== 1'b1) $display("FAIL correct_which_res got %0b/%0b want 0/1", upd_which_pdt, upd_branch_res); else n_pass++;
    n_checks++; if (upd_history !== 10'h2A5 || upd_pc !== 32'h100) $display("FAIL correct_hist_pc got %h/%h want 2a5/100", upd_history, upd_pc); else n_pass++;
    n_checks++; if (flush !== 1'b0 || spurious !== 1'b0) $display("FAIL correct_flush got %0b/%0b want 0/0", flush, spurious); else n_pass++;
    n_checks++; if (stat_branches !== 32'd1 || stat_mispred !== 32'd0) $display("FAIL correct_stats got %0d/%0d want 1/0", stat_branches, stat_mispred); else n_pass++;
    idle();
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL correct_pulse_end got %0b want 0", upd_valid); else n_pass++;
    n_checks++; if (upd_history !== 10'h2A5) $display("FAIL correct_hist_hold got %h want 2a5", upd_history); else n_pass++;
  endtask

  task automatic test_mispredict();
    push_e(32'h100, 0, 1, 10'h001, 32'h104);
    push_e(32'h104, 0, 0, 10'h002, 32'h108);
    push_e(32'h108, 0, 0, 10'h003, 32'h10C);
    resolve_e(32'h100, 1, 32'h200);
    n_checks++; if (flush !== 1'b1 || redirect_pc !== 32'h200) $display("FAIL mis_flush got %0b/%h want 1/200", flush, redirect_pc); else n_pass++;
    n_checks++; if (upd_valid !== 1'b1 || upd_pdt_true !== 1'b0) $display("FAIL mis_upd got %0b/%0b want 1/0", upd_valid, upd_pdt_true); else n_pass++;
    n_checks++; if (stat_mispred !== m_sm || m_sm !== 32'd1) $display("FAIL mis_stat got %0d want 1", stat_mispred); else n_pass++;
    resolve_e(32'h104, 0, 32'h108);
    n_checks++; if (spurious !== 1'b1 || upd_valid !== 1'b0) $display("FAIL mis_empty_after got spur=%0b valid=%0b want 1/0", spurious, upd_valid); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL mis_flush_pulse got %0b want 0", flush); else n_pass++;
  endtask

  task automatic test_full();
    logic [31:0] rest [4];
    rest = '{32'h404, 32'h408, 32'h40C, 32'h414};
    for (int i = 0; i < 4; i++) push_e(32'h400 + 32'(4 * i), 0, 0, 10'(i), 32'h0);
    push_e(32'h410, 0, 0, 10'h3FF, 32'h0);
    n_checks++; if (obs_stall !== 1'b1) $display("FAIL full_stall got %0b want 1", obs_stall); else n_pass++;
    cycle(1, 1, 32'h414, 0, 1, 10'h155, 32'h0, 1, 32'h400, 0, 32'h404);
    n_checks++; if (obs_stall !== 1'b0) $display("FAIL full_stall_pop got %0b want 0", obs_stall); else n_pass++;
    n_checks++; if (upd_valid !== 1'b1 || upd_pdt_true !== 1'b1 || flush !== 1'b0) $display("FAIL full_pop got %0b/%0b/%0b want 1/1/0", upd_valid, upd_pdt_true, flush); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      resolve_e(rest[i], 0, rest[i] + 4);
      n_checks++;
      if (upd_valid !== 1'b1 || upd_pc !== rest[i] || upd_pdt_true !== 1'b1)
        $display("FAIL full_drain%0d got %0b/%h/%0b want 1/%h/1", i, upd_valid, upd_pc, upd_pdt_true, rest[i]);
      else n_pass++;
    end
    n_checks++; if (upd_which_pdt !== 1'b1 || upd_history !== 10'h155) $display("FAIL full_reused_slot got %0b/%h want 1/155", upd_which_pdt, upd_history); else n_pass++;
    resolve_e(32'h418, 0, 32'h41C);
    n_checks++; if (spurious !== 1'b1 || upd_valid !== 1'b0) $display("FAIL full_dropped_push got %0b/%0b want 1/0", spurious, upd_valid); else n_pass++;
  endtask

  task automatic test_head_mismatch();
    logic [31:0] sm_before;
    push_e(32'h300, 1, 0, 10'h0AA, 32'h340);
    sm_before = m_sm;
    resolve_e(32'h304, 1, 32'h308);
    n_checks++; if (spurious !== 1'b1 || flush !== 1'b1) $display("FAIL hm_pulses got %0b/%0b want 1/1", spurious, flush); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h308) $display("FAIL hm_redirect got %h want 308", redirect_pc); else n_pass++;
    n_checks++; if (stat_mispred !== sm_before + 1) $display("FAIL hm_stat got %0d want %0d", stat_mispred, sm_before + 1); else n_pass++;
    n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h300) $display("FAIL hm_upd got %0b/%h want 1/300", upd_valid, upd_pc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_e(32'h500 + 32'(4 * i), 1, 1, 10'h1F, 32'h600);
    cycle(0, 1, 32'h50C, 1, 1, 10'h1F, 32'h600, 1, 32'h500, 1, 32'h600);
    n_checks++; if ({upd_valid, flush, spurious} !== 3'b000) $display("FAIL rmid_pulses got %b want 000", {upd_valid, flush, spurious}); else n_pass++;
    n_checks++; if ({stat_branches, stat_mispred, redirect_pc} !== '0) $display("FAIL rmid_regs got %h/%h/%h want 0", stat_branches, stat_mispred, redirect_pc); else n_pass++;
    resolve_e(32'h500, 1, 32'h600);
    n_checks++; if (spurious !== 1'b1 || upd_valid !== 1'b0) $display("FAIL rmid_empty got %0b/%0b want 1/0", spurious, upd_valid); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [2:0] want;
    for (int i = 0; i < 9; i++) begin
      push_e(32'h700 + 32'(4 * i), 1, 0, 10'(i), 32'h800);
      resolve_e(32'h700 + 32'(4 * i), 1, 32'h800);
      want = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      n_checks++;
      if (s_upd_valid !== 1'b1 || s_stat_branches !== want)
        $display("FAIL sat_step%0d got %0b/%0d want 1/%0d", i, s_upd_valid, s_stat_branches, want);
      else n_pass++;
    end
    n_checks++; if (stat_branches !== 32'd9) $display("FAIL sat_wide got %0d want 9", stat_branches); else n_pass++;
  endtask

  task automatic test_random();
    logic p, rs, tk, r;
    logic [31:0] ipc, tgt, ppc, ptgt;
    logic [ENT_W-1:0] h;
    for (int n = 0; n < 500; n++) begin
      r   = ($urandom_range(0, 63) != 0);
      p   = ($urandom_range(0, 1) == 1);
      ppc = 32'(12'h900 + 4 * $urandom_range(0, 15));
      ptgt = $urandom_range(0, 1) ? ppc + 4 : 32'(16'hA000 + 4 * $urandom_range(0, 7));
      rs  = ($urandom_range(0, 9) < 4);
      tk  = ($urandom_range(0, 1) == 1);
      ipc = 32'(12'h900 + 4 * $urandom_range(0, 15));
      tgt = $urandom_range(0, 1) ? ipc + 4 : 32'(16'hA000 + 4 * $urandom_range(0, 7));
      if (exp_q.size() > 0 && $urandom_range(0, 9) < 8) begin
        h = exp_q[0];
        ipc = head_pc_of(h);
        if ($urandom_range(0, 9) < 7) begin tk = h[ENT_W-33]; tgt = tk ? h[31:0] : ipc + 4; end
      end
      cycle(r, p, ppc, $urandom_range(0, 1), $urandom_range(0, 1), 10'($urandom), ptgt, rs, ipc, tk, tgt);
      n_checks++;
      if (obs_stall !== m_stall) $display("FAIL rnd_stall n=%0d got %0b want %0b", n, obs_stall, m_stall);
      else n_pass++;
      n_checks++;
      if ({upd_valid, upd_branch_res, upd_pdt_true, upd_which_pdt, upd_pc, upd_history, flush, redirect_pc, spurious, stat_branches, stat_mispred}
          !== {m_upd_valid, m_br_res, m_pdt_true, m_which, m_upd_pc, m_hist, m_flush, m_redirect, m_spur, m_sb, m_sm})
        $display("FAIL rnd_outputs n=%0d got v%0b r%0b t%0b w%0b pc%h h%h f%0b rd%h s%0b %0d/%0d want v%0b r%0b t%0b w%0b pc%h h%h f%0b rd%h s%0b %0d/%0d",
                 n, upd_valid, upd_branch_res, upd_pdt_true, upd_which_pdt, upd_pc, upd_history, flush, redirect_pc, spurious, stat_branches, stat_mispred,
                 m_upd_valid, m_br_res, m_pdt_true, m_which, m_upd_pc, m_hist, m_flush, m_redirect, m_spur, m_sb, m_sm);
      else n_pass++;
      n_checks++;
      if ({s_stat_branches, s_stat_mispred} !== {m_ssb, m_ssm})
        $display("FAIL rnd_sat_counters n=%0d got %0d/%0d want %0d/%0d", n, s_stat_branches, s_stat_mispred, m_ssb, m_ssm);
      else n_pass++;
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b0; if_push = 1'b0; if_pc = '0; if_pdt_res = 1'b0; if_which_pdt = 1'b0;
    if_history = '0; if_pdt_pc = '0; id_resolve = 1'b0; id_pc = '0; id_taken = 1'b0;
    id_target = '0;
    test_reset();
    test_correct();
    test_mispredict();
    test_full();
    test_head_mismatch();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Closing half of the branch-prediction loop. Sits between IF, ID and the predictor (`pdt`).
- Queues each prediction the predictor issues at IF: pc, taken bit, chosen sub-predictor, history snapshot.
- When ID resolves the branch, compares the actual outcome with the queued prediction.
- Drives the one-cycle predictor update bundle, and the flush/redirect to pc_reg/ctrl on a mispredict.

Parameters:
- DEPTH, 4, number of in-flight prediction entries; power of two, ≥2.
- HIST_W, 10, global history width; matches the predictor history bus.
- ADDR_W, 32, instruction address width (`InstAddrBus`).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the clock edge).
- if_push  in  1  predictor issued a prediction this cycle (branch_or_not).
- if_pc  in  ADDR_W  pc of the predicted branch.
- if_pdt_res  in  1  predicted taken.
- if_which_pdt  in  1  sub-predictor used: 0 local, 1 global.
- if_history  in  HIST_W  history snapshot at prediction time.
- if_pdt_pc  in  ADDR_W  predicted next pc.
- id_resolve  in  1  ID resolved a branch this cycle.
- id_pc  in  ADDR_W  pc of the resolved branch.
- id_taken  in  1  actual outcome.
- id_target  in  ADDR_W  correct next pc (target or pc+4).
- if_stall  out  1  queue full and no pop this cycle; IF must hold.
- upd_valid  out  1  one-cycle pulse to the predictor (id_is_branch).
- upd_branch_res  out  1  actual outcome.
- upd_pdt_true  out  1  prediction was correct.
- upd_which_pdt  out  1  sub-predictor to train.
- upd_pc  out  ADDR_W  pc to train.
- upd_history  out  HIST_W  history to train.
- flush  out  1  one-cycle pulse: kill younger instructions.
- redirect_pc  out  ADDR_W  fetch address; valid while flush=1.
- spurious  out  1  one-cycle pulse: resolve arrived with an empty queue or a mismatched head pc.
- stat_branches  out  CNT_W  resolved-branch count, saturating.
- stat_mispred  out  CNT_W  mispredict count, saturating.

Behaviour:
- Reset (rst==0 at an edge):
  - Queue emptied: rd_ptr = wr_ptr = 0, count = 0.
  - All outputs 0, including both counters and redirect_pc.
  - Takes priority over every other input, including mid-operation.
- Queue:
  - Circular FIFO of {pc, pdt_res, which_pdt, history, pdt_pc}; pointers wrap modulo DEPTH.
  - count has range 0..DEPTH.
- Push:
  - Occurs when if_push=1 and not full, or when if_push=1, full and a pop happens in the same cycle (the freed slot is reused).
  - if_stall is combinational: (count==DEPTH) && !pop_this_cycle.
  - A push while if_stall=1 is dropped.
- Pop (id_resolve=1, count>0): head entry compared against the resolve inputs.
  - mispredict = (head.pdt_res != id_taken) || (id_taken && head.pdt_pc != id_target).
- Registered outputs on the edge after id_resolve (latency 1):
  - upd_valid=1; upd_branch_res=id_taken; upd_pdt_true=!mispredict.
  - upd_which_pdt, upd_pc, upd_history taken from the head entry.
  - stat_branches +1; stat_mispred +1 on a mispredict. Both hold at all-ones.
- Mispredict:
  - flush=1, redirect_pc=id_target, same cycle as upd_valid.
  - Every remaining entry is discarded: wr_ptr=rd_ptr_next, count=0.
  - Any push in the same cycle is dropped, because it is wrong-path.
- Spurious resolve, either case:
  - Queue empty: no pop, upd_valid stays 0, spurious=1.
  - Head pc != id_pc: head popped, treated as a mispredict with redirect_pc=id_target, spurious=1, counters updated.
- Pulses:
  - upd_valid, flush and spurious are high for exactly one cycle.
  - Their data fields hold their last value when the pulse is low.
- Simultaneous push and pop with no mispredict: count is unchanged and both pointers advance.
- At most one push and one pop per cycle.

Decomposition:
- Shared defines header: RstEnable/RstDisable levels, InstAddrBus, HIST_W default, OPCODE_BRANCH (7'b1100011).
- One sub-module, bp_meta_fifo: a parameterised FIFO with push/pop/clear, full/empty and count.
- Compare, update and statistics logic stays in branch_resolve.

Test Plan:
- Single correct prediction:
  - Stimulus: push pc=0x100, pdt_res=1, which=0, hist=0x2A5, pdt_pc=0x140; next cycle resolve pc=0x100, taken=1, target=0x140.
  - Required: next cycle upd_valid=1, pdt_true=1, which=0, hist=0x2A5; flush=0; stat_branches=1, stat_mispred=0.
- Mispredict flushes younger entries:
  - Stimulus: push 0x100 (pdt_res=0), 0x104, 0x108; resolve 0x100 with taken=1, target=0x200.
  - Required: flush=1, redirect_pc=0x200, upd_pdt_true=0, count=0; a subsequent resolve gives spurious=1.
- Full queue:
  - Stimulus: 4 pushes with no resolve.
  - Required: if_stall=1 and a 5th push is dropped.
  - Stimulus: push and a correct resolve in the same cycle.
  - Required: if_stall=0, the push is accepted, count stays 4.
- Head mismatch:
  - Stimulus: queue head pc=0x300; resolve pc=0x304, target=0x308.
  - Required: spurious=1, flush=1, redirect_pc=0x308, stat_mispred incremented.
- Reset mid-operation:
  - Stimulus: 3 entries queued, then rst=0 for one edge together with id_resolve=1.
  - Required: all outputs 0, no upd_valid pulse, queue empty after rst returns high.
- Counter saturation:
  - Stimulus: force stat_branches to 0xFFFFFFFF, then one correct resolve.
  - Required: stat_branches stays 0xFFFFFFFF and upd_valid still pulses.
